ecc_encoder: RTL and testbench
==============================

# ecc_encoder

Extended-Hamming (SECDED) encoder for the error-correction accelerator. It accepts data words over a valid/ready handshake, generates 8-, 16- or 32-bit codewords for the selected codeword width, and buffers them in a 2-entry output FIFO. The output side applies backpressure. The codeword bit layout is exactly the one the accelerator's decode path checks, so encode→decode round-trips with zero errors.

## Interface
- AMBA_WORD, 32, width of the configuration word that carries the codeword-width field
- DATA_WIDTH, 32, width of the data and codeword buses
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- codeword_width  in  AMBA_WORD  bits [1:0] select the mode: 00 = 8-bit (4 data bits), 01 = 16-bit (11 data bits), 10 or 11 = 32-bit (26 data bits)
- in_valid  in  1  input word present
- in_ready  out  1  encoder can accept a word
- data_in  in  DATA_WIDTH  payload; only the low 4, 11 or 26 bits are used, the rest are ignored
- out_valid  out  1  codeword available at the FIFO head
- out_ready  in  1  consumer accepts the codeword
- data_out  out  DATA_WIDTH  codeword, zero-extended above the codeword length
- out_width  out  2  codeword_width[1:0] captured with this entry

## Operation
- Accept occurs when in_valid && in_ready. On accept, the codeword is computed combinationally from data_in and codeword_width[1:0] sampled in that same cycle, then written to the FIFO tail together with the width tag.
- Codeword bits c[n] and data bits d[k] map as follows:
  - 8-bit mode: c[7:4] = d[3:0].
    - c2 = c5^c6^c7; c1 = c4^c6^c7; c0 = c4^c5^c7.
    - c3 = XOR of all other bits in c[7:0].
  - 16-bit mode: c[15:5] = d[10:0].
    - c3 = XOR c[15:9].
    - c2 = c6^c7^c8^c12^c13^c14^c15.
    - c1 = c5^c7^c8^c10^c11^c14^c15.
    - c0 = c5^c6^c8^c9^c11^c13^c15.
    - c4 = XOR of all other bits in c[15:0].
  - 32-bit mode: c[31:6] = d[25:0].
    - c4 = XOR c[31:17].
    - c3 = XOR c[16:10], c[31:24].
    - c2 = XOR c7,c8,c9, c[16:13], c[23:20], c[31:28].
    - c1 = XOR c6,c8,c9,c11,c12,c15,c16,c18,c19,c22,c23,c26,c27,c30,c31.
    - c0 = XOR c6,c7,c9,c10,c12,c14,c16,c17,c19,c21,c23,c25,c27,c29,c31.
    - c5 = XOR of all other bits in c[31:0].
- Output side:
  - The FIFO holds 2 entries, using a 2-bit occupancy count (0..2) and 1-bit read and write pointers that wrap.
  - Pop occurs when out_valid && out_ready.
  - out_valid = (count != 0).
  - in_ready = (count != 2). in_ready is a registered-state function only, with no combinational path from out_ready.
- Simultaneous push and pop:
  - With count 1: count stays 1, and the head advances to the newly written entry.
  - With count 0: there is no pop (out_valid is low), so count becomes 1.
  - With count 2: a push cannot occur because in_ready is low; the pop alone brings count to 1.
- A codeword_width change takes effect on the next accepted word. Entries already in the FIFO keep their captured tag.

## Timing
- Reset values: in_ready = 0 while reset is asserted and 1 from the first clock after release; out_valid = 0; data_out = 0; out_width = 0; count = 0; both pointers = 0.
- Latency: a word accepted in cycle N is visible on data_out/out_valid in cycle N+1 when the FIFO was empty.
- Throughput is 1 word per cycle while out_ready is held high.
- data_out and out_width stay stable while out_valid && !out_ready.
- Reset asserted mid-operation clears all FIFO contents immediately (asynchronously). Buffered codewords are discarded.

## Configuration
- ECC_ENC_STATS_EN defined:
  - Adds output enc_count, 16 bits, reset 0.
  - It increments on every pop and saturates at 16'hFFFF.
- ECC_ENC_STATS_EN undefined: the port and the counter are absent, and there is no other behavioural difference.

## Structure
- Shared package ecc_pkg:
  - Width-code constants: CW_8 = 2'b00, CW_16 = 2'b01, CW_32 = 2'b10.
  - Codeword lengths: 8, 16, 32.
  - Data-bit counts: 4, 11, 26.
  - Parity-bit counts: 4, 5, 6.
- One sub-module, ecc_parity_gen: purely combinational, takes data_in and width, and returns the codeword. The FIFO and handshake logic stay in ecc_encoder.

## Test plan
- 8-bit mode, data_in = 4'hB, out_ready = 1 → next cycle out_valid = 1, data_out = 32'h000000B1, out_width = 2'b00.
- 16-bit mode, data_in = 11'h7FF → data_out = 32'h0000FFFF. 32-bit mode, data_in = 26'h1 → data_out = 32'h00000063. data_in = 0 in any mode → data_out = 0.
- out_ready = 0 with 3 back-to-back words → first two accepted, in_ready low from the third cycle; release out_ready → words emerge in order with no loss or duplication, and in_ready returns high the cycle after the first pop.
- Mode switches between consecutive words (8 → 32 → 16) while stalled → each codeword matches its own captured width; out_width is per entry.
- Assert reset with 2 entries buffered → out_valid = 0 and data_out = 0 immediately; after release, in_ready = 1 and the FIFO is empty.
- Random data, all modes, every output codeword fed to the accelerator's decode path → num_of_error = 0 and recovered data equals the input; with ECC_ENC_STATS_EN defined, enc_count equals the number of pops.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared constants for the SECDED encoder: width codes, codeword geometry and mode decode.
package ecc_pkg;

   localparam logic [1:0] CW_8  = 2'b00;
   localparam logic [1:0] CW_16 = 2'b01;
   localparam logic [1:0] CW_32 = 2'b10;

   localparam int CW8_LEN  = 8;
   localparam int CW16_LEN = 16;
   localparam int CW32_LEN = 32;

   localparam int CW8_DATA  = 4;
   localparam int CW16_DATA = 11;
   localparam int CW32_DATA = 26;

   localparam int CW8_PAR  = 4;
   localparam int CW16_PAR = 5;
   localparam int CW32_PAR = 6;

   typedef enum logic [1:0] {
      MODE_8  = 2'd0,
      MODE_16 = 2'd1,
      MODE_32 = 2'd2
   } mode_e;

   // Width code 2'b11 is treated as the 32-bit mode.
   function automatic mode_e decode_mode(input logic [1:0] w);
      case (w)
         CW_8:    return MODE_8;
         CW_16:   return MODE_16;
         default: return MODE_32;
      endcase
   endfunction

endpackage

// File: rtl/ecc_parity_gen.sv
// Combinational extended-Hamming codeword builder for the 8/16/32-bit layouts.
module ecc_parity_gen
   import ecc_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [1:0]            width_i,
   output logic [DATA_WIDTH-1:0] code_o
);

   logic [CW8_LEN-1:0]  c8;
   logic [CW16_LEN-1:0] c16;
   logic [CW32_LEN-1:0] c32;
   logic                unused_data;

   assign unused_data = ^data_i[DATA_WIDTH-1:CW32_DATA];

   always_comb begin
      c8 = '0;
      c8[CW8_LEN-1:CW8_PAR] = data_i[CW8_DATA-1:0];
      c8[2] = c8[5] ^ c8[6] ^ c8[7];
      c8[1] = c8[4] ^ c8[6] ^ c8[7];
      c8[0] = c8[4] ^ c8[5] ^ c8[7];
      c8[3] = ^{c8[7:4], c8[2:0]};
   end

   always_comb begin
      c16 = '0;
      c16[CW16_LEN-1:CW16_PAR] = data_i[CW16_DATA-1:0];
      c16[3] = ^c16[15:9];
      c16[2] = c16[6] ^ c16[7] ^ c16[8] ^ c16[12] ^ c16[13] ^ c16[14] ^ c16[15];
      c16[1] = c16[5] ^ c16[7] ^ c16[8] ^ c16[10] ^ c16[11] ^ c16[14] ^ c16[15];
      c16[0] = c16[5] ^ c16[6] ^ c16[8] ^ c16[9] ^ c16[11] ^ c16[13] ^ c16[15];
      c16[4] = ^{c16[15:5], c16[3:0]};
   end

   always_comb begin
      c32 = '0;
      c32[CW32_LEN-1:CW32_PAR] = data_i[CW32_DATA-1:0];
      c32[4] = ^c32[31:17];
      c32[3] = ^{c32[16:10], c32[31:24]};
      c32[2] = ^{c32[9:7], c32[16:13], c32[23:20], c32[31:28]};
      c32[1] = ^{c32[6], c32[9:8], c32[12:11], c32[16:15], c32[19:18],
                 c32[23:22], c32[27:26], c32[31:30]};
      c32[0] = ^{c32[6], c32[7], c32[9], c32[10], c32[12], c32[14], c32[16], c32[17],
                 c32[19], c32[21], c32[23], c32[25], c32[27], c32[29], c32[31]};
      c32[5] = ^{c32[31:6], c32[4:0]};
   end

   always_comb begin
      code_o = '0;
      case (decode_mode(width_i))
         MODE_8:  code_o[CW8_LEN-1:0]  = c8;
         MODE_16: code_o[CW16_LEN-1:0] = c16;
         default: code_o[CW32_LEN-1:0] = c32;
      endcase
   end

endmodule

// File: rtl/ecc_encoder.sv
// SECDED encoder with a 2-entry output FIFO and valid/ready on both sides.
// Optional macro ECC_ENC_STATS_EN adds the saturating pop counter enc_count.
module ecc_encoder
   import ecc_pkg::*;
#(
   parameter int AMBA_WORD  = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [AMBA_WORD-1:0]  codeword_width,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [1:0]            out_width
`ifdef ECC_ENC_STATS_EN
   ,
   output logic [15:0]           enc_count
`endif
);

   localparam int DEPTH = 2;

   logic [1:0]            count_q, count_d;
   logic                  wr_ptr_q, rd_ptr_q;
   logic                  init_q;
   logic [DATA_WIDTH-1:0] mem_data_q  [DEPTH];
   logic [1:0]            mem_width_q [DEPTH];
   logic [DATA_WIDTH-1:0] code;
   logic                  push, pop;
   logic                  unused_cfg;

   assign unused_cfg = ^codeword_width[AMBA_WORD-1:2];

   ecc_parity_gen #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity (
      .data_i  (data_in),
      .width_i (codeword_width[1:0]),
      .code_o  (code)
   );

   // init_q keeps in_ready low until the first clock after reset release.
   assign in_ready  = init_q && (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + 2'd1;
      else if (pop && !push) count_d = count_q - 2'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         init_q   <= 1'b0;
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_data_q[i]  <= '0;
            mem_width_q[i] <= 2'b00;
         end
      end else begin
         init_q  <= 1'b1;
         count_q <= count_d;
         if (push) begin
            mem_data_q[wr_ptr_q]  <= code;
            mem_width_q[wr_ptr_q] <= codeword_width[1:0];
            wr_ptr_q              <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
   end

   // Outputs read as zero whenever the FIFO is empty.
   assign data_out  = out_valid ? mem_data_q[rd_ptr_q]  : '0;
   assign out_width = out_valid ? mem_width_q[rd_ptr_q] : 2'b00;

`ifdef ECC_ENC_STATS_EN
   logic [15:0] enc_count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                             enc_count_q <= 16'h0000;
      else if (pop && enc_count_q != 16'hFFFF) enc_count_q <= enc_count_q + 16'h0001;
   end

   assign enc_count = enc_count_q;
`endif

endmodule

// File: tb/tb_ecc_encoder.sv
// Self-checking bench for ecc_encoder: directed vector table, handshake corners, random scoreboard.
module tb_ecc_encoder;

   logic        clk;
   logic        reset;
   logic [31:0] codeword_width;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] data_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] data_out;
   logic [1:0]  out_width;
`ifdef ECC_ENC_STATS_EN
   logic [15:0] enc_count;
`endif

   int checks = 0;
   int fails  = 0;
   int pops   = 0;

   ecc_encoder #(.AMBA_WORD(32), .DATA_WIDTH(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .codeword_width (codeword_width),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .data_in        (data_in),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .data_out       (data_out),
      .out_width      (out_width)
`ifdef ECC_ENC_STATS_EN
      ,
      .enc_count      (enc_count)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [1:0]  w;
      logic [31:0] din;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [31:0] code;
      logic [1:0]  w;
      logic [31:0] data;
   } entry_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Number of Hamming check bits (overall parity excluded) for a width code.
   function automatic int ham_bits(input logic [1:0] w);
      if (w == 2'b00) return 3;
      if (w == 2'b01) return 4;
      return 5;
   endfunction

   function automatic logic [31:0] data_mask(input logic [1:0] w);
      int r = ham_bits(w);
      int k = (1 << r) - r - 1;
      return (32'h1 << k) - 32'h1;
   endfunction

   // Classic Hamming: data fill non-power-of-two positions in order, check bit i = XOR of
   // positions with bit i set; overall parity sits just above the check bits.
   function automatic logic [31:0] model_enc(input logic [1:0] w, input logic [31:0] d);
      int r = ham_bits(w);
      int n = 1 << r;
      int j = 0;
      int syn = 0;
      logic [31:0] c = '0;
      for (int p = 1; p < n; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (d[j]) begin
               c[r + 1 + j] = 1'b1;
               syn ^= p;
            end
            j++;
         end
      end
      for (int i = 0; i < r; i++) c[i] = syn[i];
      c[r] = ^c;
      return c;
   endfunction

   // Decode path: returns 0 when syndrome, overall parity and padding are all clean.
   function automatic int model_dec(input logic [1:0] w, input logic [31:0] c,
                                    output logic [31:0] d);
      int r = ham_bits(w);
      int n = 1 << r;
      int j = 0;
      int syn = 0;
      logic ovl = 1'b0;
      logic pad = 1'b0;
      d = '0;
      for (int p = 1; p < n; p++) begin
         if ((p & (p - 1)) != 0) begin
            d[j] = c[r + 1 + j];
            if (c[r + 1 + j]) syn ^= p;
            j++;
         end
      end
      for (int i = 0; i < r; i++) if (c[i]) syn ^= (1 << i);
      for (int i = 0; i < 32; i++) begin
         if (i < n) ovl ^= c[i];
         else       pad |= c[i];
      end
      if (syn == 0 && !ovl && !pad) return 0;
      return (ovl ? 1 : 2);
   endfunction

   vec_t        tab[$];
   entry_t      q[$];
   entry_t      e;
   logic [31:0] cA, cB, cC, dec_d;
   logic [1:0]  rw;
   logic [31:0] rd;
   logic        do_push, do_pop;
   int          errs;

   initial begin
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      data_in = '0; codeword_width = '0;

      // Upper bits of data_in and codeword_width carry garbage that must be ignored.
      tab.push_back('{2'b00, 32'hABCD_123B, 32'h0000_00B1});
      tab.push_back('{2'b01, 32'h5A5A_FFFF, 32'h0000_FFFF});
      tab.push_back('{2'b10, 32'hFC00_0001, 32'h0000_0063});
      tab.push_back('{2'b11, 32'h0000_0001, 32'h0000_0063});
      tab.push_back('{2'b00, 32'hFFFF_FFF0, 32'h0000_0000});
      tab.push_back('{2'b01, 32'hFFFF_F800, 32'h0000_0000});
      tab.push_back('{2'b10, 32'hFC00_0000, 32'h0000_0000});

      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready",  {31'b0, in_ready},  32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_data_out",  data_out,           32'd0);
      chk("rst_out_width", {30'b0, out_width}, 32'd0);
      reset = 1'b1;
      step();
      chk("post_rst_in_ready",  {31'b0, in_ready},  32'd1);
      chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);

      // Vector table at full throughput.
      out_ready = 1'b1;
      foreach (tab[i]) begin
         codeword_width = {$urandom} & 32'hFFFF_FFFC | {30'b0, tab[i].w};
         data_in  = tab[i].din;
         in_valid = 1'b1;
         step();
         chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
         chk($sformatf("vec%0d_data", i),  data_out,           tab[i].exp);
         chk($sformatf("vec%0d_width", i), {30'b0, out_width}, {30'b0, tab[i].w});
      end
      in_valid = 1'b0;
      step();
      chk("vec_drain_valid", {31'b0, out_valid}, 32'd0);

      // Backpressure with mode switches 8 -> 32 -> 16.
      cA = model_enc(2'b00, 32'h0000_0005);
      cB = model_enc(2'b10, 32'h02AB_CDEF);
      cC = model_enc(2'b01, 32'h0000_05A3);
      out_ready = 1'b0;
      in_valid = 1'b1; codeword_width = 32'h0; data_in = 32'h0000_0005;
      step();
      chk("bp1_in_ready", {31'b0, in_ready}, 32'd1);
      chk("bp1_data",     data_out,          cA);
      codeword_width = 32'h2; data_in = 32'h02AB_CDEF;
      step();
      chk("bp2_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp2_data",     data_out,          cA);
      codeword_width = 32'h1; data_in = 32'h0000_05A3;
      step();
      chk("bp3_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp3_data",     data_out,          cA);
      chk("bp3_width",    {30'b0, out_width}, 32'd0);
      out_ready = 1'b1;
      step();
      chk("bp4_in_ready", {31'b0, in_ready}, 32'd1);
      chk("bp4_data",     data_out,          cB);
      chk("bp4_width",    {30'b0, out_width}, 32'd2);
      step();
      chk("bp5_valid", {31'b0, out_valid}, 32'd1);
      chk("bp5_data",  data_out,           cC);
      chk("bp5_width", {30'b0, out_width}, 32'd1);
      in_valid = 1'b0;
      step();
      chk("bp6_valid", {31'b0, out_valid}, 32'd0);

      // Reset with two entries buffered.
      out_ready = 1'b0; in_valid = 1'b1;
      codeword_width = 32'h2; data_in = 32'h0123_4567;
      step();
      step();
      in_valid = 1'b0;
      chk("full_valid",    {31'b0, out_valid}, 32'd1);
      chk("full_in_ready", {31'b0, in_ready},  32'd0);
      reset = 1'b0;
      #1;
      chk("arst_valid",    {31'b0, out_valid}, 32'd0);
      chk("arst_data",     data_out,           32'd0);
      chk("arst_width",    {30'b0, out_width}, 32'd0);
      chk("arst_in_ready", {31'b0, in_ready},  32'd0);
      #3 reset = 1'b1;
      step();
      chk("arst_rel_in_ready", {31'b0, in_ready},  32'd1);
      chk("arst_rel_valid",    {31'b0, out_valid}, 32'd0);

      // Random traffic against a queue model and the decode path.
      for (int it = 0; it < 400; it++) begin
         rw = 2'($urandom);
         rd = $urandom;
         if (it >= 396) begin
            in_valid = 1'b0; out_ready = 1'b1;
         end else begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
         end
         codeword_width = {$urandom} & 32'hFFFF_FFFC | {30'b0, rw};
         data_in = rd;
         #1;
         chk("rnd_out_valid", {31'b0, out_valid}, {31'b0, (q.size() != 0)});
         chk("rnd_in_ready",  {31'b0, in_ready},  {31'b0, (q.size() < 2)});
         do_pop  = (q.size() != 0) && out_ready;
         do_push = (q.size() < 2) && in_valid;
         if (do_pop) begin
            e = q.pop_front();
            chk("rnd_data",  data_out,           e.code);
            chk("rnd_width", {30'b0, out_width}, {30'b0, e.w});
            errs = model_dec(e.w, data_out, dec_d);
            chk("rnd_dec_errors", errs, 0);
            chk("rnd_dec_data",   dec_d, e.data);
            pops++;
         end
         if (do_push) q.push_back('{model_enc(rw, rd), rw, rd & data_mask(rw)});
         @(posedge clk);
         #1;
      end
      chk("rnd_empty", {31'b0, out_valid}, 32'd0);
`ifdef ECC_ENC_STATS_EN
      chk("enc_count", {16'b0, enc_count}, pops);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
